// File: rtl/mul_add_job_ctrl.sv
// mul_add_job_ctrl: job front-end for the repeated-addition multiplier.
// Accepts operand pairs, sequences re-arm/start of the external control path,
// drives its shared operand bus, and returns the product (or a watchdog abort).
module mul_add_job_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 300
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_err,
   output logic               mul_rst,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_data,
   input  logic               mul_lda,
   input  logic               mul_ldb,
   input  logic               mul_done,
   input  logic [2*WIDTH-1:0] mul_prod
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]    p_q, p_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             start_q, start_d;
   logic [CW-1:0]    wd_q, wd_d;

   // Next-state and next-output logic for the job sequencer
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      err_d   = err_q;
      valid_d = valid_q;
      start_d = start_q;
      wd_d    = wd_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d = in_a;
               b_d = in_b;
               if ((in_a == '0) || (in_b == '0)) begin
                  // zero operand: answer locally, multiplier stays untouched
                  p_d     = '0;
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = CLR;
               end
            end
         end

         CLR: begin
            wd_d    = '0;
            start_d = 1'b1;
            state_d = RUN;
         end

         RUN: begin
            wd_d = wd_q + CW'(1);
            if (mul_lda) begin
               start_d = 1'b0;
            end
            // done has priority over a simultaneous watchdog expiry
            if (mul_done) begin
               p_d     = mul_prod;
               err_d   = 1'b0;
               valid_d = 1'b1;
               start_d = 1'b0;
               state_d = RESP;
            end else if (wd_q == WD_LAST) begin
               p_d     = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
               start_d = 1'b0;
               state_d = RESP;
            end
         end

         RESP: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            start_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         start_q <= start_d;
         wd_q    <= wd_d;
      end
   end

   // Handshake and multiplier interface
   always_comb begin
      in_ready  = (state_q == IDLE);
      mul_rst   = rst | (state_q == CLR);
      mul_data  = mul_ldb ? b_q : a_q;
      out_valid = valid_q;
      out_p     = p_q;
      out_err   = err_q;
      mul_start = start_q;
   end

endmodule

// File: tb/tb_mul_add_job_ctrl.sv
// Bench for mul_add_job_ctrl with a behavioural repeated-addition multiplier.
module tb_mul_add_job_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned TO = 300;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic          out_valid, out_ready;
   logic [15:0]   out_p;
   logic          out_err;
   logic          mul_rst, mul_start;
   logic [W-1:0]  mul_data;
   logic          mul_lda, mul_ldb, mul_done;
   logic [15:0]   mul_prod;

   int total = 0;
   int bad   = 0;
   bit stuck = 1'b0;

   always #5 clk = ~clk;

   mul_add_job_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err),
      .mul_rst(mul_rst), .mul_start(mul_start), .mul_data(mul_data),
      .mul_lda(mul_lda), .mul_ldb(mul_ldb), .mul_done(mul_done), .mul_prod(mul_prod)
   );

   // Repeated-addition multiplier: load A, load B, add A B times, sticky done
   typedef enum logic [2:0] {M_S0, M_LDA, M_LDB, M_ADD, M_DONE} m_t;
   m_t          ms = M_S0;
   logic [7:0]  ma = '0, mb = '0;
   logic [15:0] mp = '0;

   always @(posedge clk) begin
      if (mul_rst) begin
         ms <= M_S0;
         mp <= '0;
      end else begin
         case (ms)
            M_S0:   if (mul_start) ms <= M_LDA;
            M_LDA:  begin ma <= mul_data; ms <= M_LDB; end
            M_LDB:  begin mb <= mul_data; mp <= '0; ms <= (mul_data == '0) ? M_DONE : M_ADD; end
            M_ADD:  begin mp <= mp + 16'(ma); mb <= mb - 8'd1; if (mb == 8'd1) ms <= M_DONE; end
            default: ms <= ms;
         endcase
      end
   end

   assign mul_lda  = (ms == M_LDA);
   assign mul_ldb  = (ms == M_LDB);
   assign mul_done = (ms == M_DONE) && !stuck;
   assign mul_prod = mp;

   function automatic logic [16:0] ref_result(input logic [7:0] a, input logic [7:0] b, input bit hang);
      if (a == 0 || b == 0) return {1'b0, 16'd0};
      if (hang)             return {1'b1, 16'd0};
      return {1'b0, 16'(int'(a) * int'(b))};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // results of the last job, written only by do_job
   logic [15:0] r_p;
   logic        r_err;
   int          r_lat, r_first_start, r_rst_cnt, r_start_cnt, r_hold_bad;
   bit          r_start_at_lda, r_start_after_lda, r_timeout, r_drop_ok;

   task automatic do_job(input logic [7:0] a, input logic [7:0] b, input int hold);
      bit lda_seen;
      int guard;
      r_lat = 0; r_first_start = -1; r_rst_cnt = 0; r_start_cnt = 0; r_hold_bad = 0;
      r_start_at_lda = 1'b0; r_start_after_lda = 1'b0; r_timeout = 1'b0; lda_seen = 1'b0;
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      if (!in_ready) begin r_timeout = 1'b1; return; end
      in_valid = 1'b1; in_a = a; in_b = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      r_lat = 1;
      forever begin
         if (mul_rst) r_rst_cnt++;
         if (mul_start) begin
            r_start_cnt++;
            if (r_first_start < 0) r_first_start = r_lat;
            if (lda_seen) r_start_after_lda = 1'b1;
         end
         if (mul_lda && !lda_seen) begin lda_seen = 1'b1; r_start_at_lda = mul_start; end
         if (out_valid) break;
         if (r_lat > 2000) begin r_timeout = 1'b1; break; end
         @(negedge clk);
         r_lat++;
      end
      r_p = out_p; r_err = out_err;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         if (!out_valid || in_ready || out_p !== r_p || out_err !== r_err || mul_start) r_hold_bad++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      r_drop_ok = !out_valid && in_ready;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      bit          hang;
      int          hold;
      logic [15:0] exp_p;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{8'd5,   8'd3,   1'b0, 0,  16'd15,    1'b0};
      vecs[1] = '{8'd0,   8'd200, 1'b0, 0,  16'd0,     1'b0};
      vecs[2] = '{8'd9,   8'd0,   1'b0, 0,  16'd0,     1'b0};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 10, 16'd65025, 1'b0};
      vecs[4] = '{8'd7,   8'd6,   1'b0, 0,  16'd42,    1'b0};
      vecs[5] = '{8'd10,  8'd10,  1'b1, 2,  16'd0,     1'b1};
      vecs[6] = '{8'd12,  8'd11,  1'b0, 0,  16'd132,   1'b0};
      vecs[7] = '{8'd1,   8'd255, 1'b0, 1,  16'd255,   1'b0};
      vecs[8] = '{8'd255, 8'd1,   1'b0, 0,  16'd255,   1'b0};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_p",     32'(out_p),     32'd0);
      chk("reset_out_err",   32'(out_err),   32'd0);
      chk("reset_mul_start", 32'(mul_start), 32'd0);
      chk("reset_mul_rst",   32'(mul_rst),   32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("release_mul_rst", 32'(mul_rst), 32'd0);

      // directed table
      foreach (vecs[i]) begin
         bit zero;
         zero  = (vecs[i].a == 0) || (vecs[i].b == 0);
         stuck = vecs[i].hang;
         do_job(vecs[i].a, vecs[i].b, vecs[i].hold);
         stuck = 1'b0;
         chk($sformatf("vec%0d_no_timeout", i), 32'(r_timeout), 32'd0);
         chk($sformatf("vec%0d_p", i),   32'(r_p),   32'(vecs[i].exp_p));
         chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_drop", i), 32'(r_drop_ok), 32'd1);
         if (vecs[i].hold > 0) chk($sformatf("vec%0d_hold_stable", i), 32'(r_hold_bad), 32'd0);
         if (zero) begin
            chk($sformatf("vec%0d_bypass_latency", i), 32'(r_lat), 32'd1);
            chk($sformatf("vec%0d_bypass_no_rst", i),  32'(r_rst_cnt), 32'd0);
            chk($sformatf("vec%0d_bypass_no_start", i), 32'(r_start_cnt), 32'd0);
         end else begin
            chk($sformatf("vec%0d_rst_pulse", i),       32'(r_rst_cnt), 32'd1);
            chk($sformatf("vec%0d_start_at_lda", i),    32'(r_start_at_lda), 32'd1);
            chk($sformatf("vec%0d_start_after_lda", i), 32'(r_start_after_lda), 32'd0);
            chk($sformatf("vec%0d_start_after_clr", i), 32'(r_first_start), 32'd2);
            if (vecs[i].hang)
               chk($sformatf("vec%0d_abort_cycles", i), 32'(r_lat - r_first_start), 32'(TO));
         end
      end

      // randomized jobs against the arithmetic reference
      for (int k = 0; k < 24; k++) begin
         logic [7:0]  a, b;
         logic [16:0] exp;
         int          hold;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) a = '0;
         if ($urandom_range(0, 7) == 0) b = '0;
         stuck = ($urandom_range(0, 9) == 0);
         hold  = int'($urandom_range(0, 3));
         exp   = ref_result(a, b, stuck);
         do_job(a, b, hold);
         stuck = 1'b0;
         chk($sformatf("rand%0d_%0dx%0d", k, a, b), 32'({r_timeout, r_err, r_p}), 32'({1'b0, exp}));
      end

      // asynchronous reset while the multiplier is being started
      @(negedge clk);
      in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("midrun_start_before_rst", 32'(mul_start), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_rst_mul_start", 32'(mul_start), 32'd0);
      chk("midrun_rst_mul_rst",   32'(mul_rst),   32'd1);
      repeat (2) @(negedge clk);
      chk("midrun_rst_held", 32'(mul_rst), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrun_release_in_ready",  32'(in_ready),  32'd1);
      chk("midrun_release_out_valid", 32'(out_valid), 32'd0);
      do_job(8'd3, 8'd4, 0);
      chk("after_rst_job", 32'({r_timeout, r_err, r_p}), 32'({1'b0, 1'b0, 16'd12}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global bound so the bench cannot hang
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time bound");
      $fatal(1);
   end

endmodule
